// File: rtl/ray_scheduler_pkg.sv
// Shared types for the ray scheduler: camera description, FSM states and
// pixel coordinate widths.
package ray_scheduler_pkg;

  typedef struct packed {
    logic [15:0] origin_x;
    logic [15:0] origin_y;
    logic [15:0] origin_z;
  } camera_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } sched_state_t;

  localparam int H_BITS = 11;
  localparam int V_BITS = 10;

endpackage

// File: rtl/ray_scheduler_pipeline.sv
// Generic fixed-depth shift register with synchronous clear; advances every
// cycle and presents its input DEPTH cycles later.
module ray_scheduler_pipeline #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] delayed
);

  logic [WIDTH-1:0] stages [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else begin
      stages[0] <= data;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign delayed = stages[DEPTH-1];

endmodule

// File: rtl/ray_scheduler.sv
// Frame sequencer for ray_maker: raster-scans pixels under downstream credit
// control, holds the camera stable for the frame and tags coords with ray_valid.
module ray_scheduler
  import ray_scheduler_pkg::*;
#(
  parameter int WIDTH   = 1280,
  parameter int HEIGHT  = 720,
  parameter int LATENCY = 28,
  parameter int CREDITS = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  camera_t            cam_in,
  input  logic               credit_return,
  output camera_t            cam_out,
  output logic               new_ray,
  output logic [H_BITS-1:0]  pixel_h,
  output logic [V_BITS-1:0]  pixel_v,
  output logic               tag_valid,
  output logic [H_BITS-1:0]  tag_h,
  output logic [V_BITS-1:0]  tag_v,
  output logic               busy,
  output logic               frame_done,
  output logic [15:0]        frame_count
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam int DW = $clog2(LATENCY + 1);
  localparam logic [H_BITS-1:0] H_LAST     = H_BITS'(WIDTH - 1);
  localparam logic [V_BITS-1:0] V_LAST     = V_BITS'(HEIGHT - 1);
  localparam logic [CW-1:0]     CREDIT_MAX = CW'(CREDITS);
  localparam logic [DW-1:0]     DRAIN_LOAD = DW'(LATENCY);

  if (WIDTH < 1 || WIDTH > 2047 || HEIGHT < 1 || HEIGHT > 1023 ||
      LATENCY < 1 || CREDITS < 1) begin : g_param_check
    $error("ray_scheduler: WIDTH/HEIGHT/LATENCY/CREDITS out of range");
  end

  sched_state_t      state;
  logic [H_BITS-1:0] h;
  logic [V_BITS-1:0] v;
  logic [CW-1:0]     credits;
  logic [DW-1:0]     drain_cnt;
  logic              issue;
  logic              take_return;

  // Issue looks only at the registered credit count; a return arriving while
  // the pool is already full has no slot to give back and is dropped.
  assign issue       = (state == RUN) && (credits != '0);
  assign take_return = credit_return && (issue || credits != CREDIT_MAX);
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      h           <= '0;
      v           <= '0;
      credits     <= CREDIT_MAX;
      drain_cnt   <= '0;
      cam_out     <= '0;
      new_ray     <= 1'b0;
      pixel_h     <= '0;
      pixel_v     <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      new_ray    <= 1'b0;
      frame_done <= 1'b0;

      if (issue && !take_return)      credits <= credits - CW'(1);
      else if (!issue && take_return) credits <= credits + CW'(1);

      case (state)
        IDLE: begin
          if (start) begin
            cam_out <= cam_in;
            h       <= '0;
            v       <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          if (issue) begin
            new_ray <= 1'b1;
            pixel_h <= h;
            pixel_v <= v;
            if (h == H_LAST) begin
              h <= '0;
              if (v == V_LAST) begin
                v         <= '0;
                drain_cnt <= DRAIN_LOAD;
                state     <= DRAIN;
              end else begin
                v <= v + V_BITS'(1);
              end
            end else begin
              h <= h + H_BITS'(1);
            end
          end
        end
        // The last tag leaves the delay line before the done pulse is raised.
        DRAIN: begin
          if (drain_cnt == '0) begin
            frame_done  <= 1'b1;
            frame_count <= frame_count + 16'd1;
            state       <= DONE;
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  ray_scheduler_pipeline #(
    .WIDTH (1 + H_BITS + V_BITS),
    .DEPTH (LATENCY)
  ) u_tag_delay (
    .clk     (clk),
    .rst     (rst),
    .data    ({new_ray, pixel_h, pixel_v}),
    .delayed ({tag_valid, tag_h, tag_v})
  );

endmodule

// File: tb/tb_ray_scheduler.sv
// Directed bench for ray_scheduler: three instances (16, 2 and 1 credits) on a
// 4x2 frame with a 3-cycle ray_maker latency.
module tb_ray_scheduler;
  import ray_scheduler_pkg::*;

  localparam int W = 4;
  localparam int H = 2;
  localparam int L = 3;

  localparam camera_t CAM1 = '{16'h1111, 16'h2222, 16'h3333};
  localparam camera_t CAM2 = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
  localparam camera_t CAM3 = '{16'h0F0F, 16'hF0F0, 16'h5A5A};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  camera_t     cam_in;
  logic        start         [3];
  logic        credit_return [3];
  camera_t     cam_out       [3];
  logic        new_ray       [3];
  logic [10:0] pixel_h       [3];
  logic [9:0]  pixel_v       [3];
  logic        tag_valid     [3];
  logic [10:0] tag_h         [3];
  logic [9:0]  tag_v         [3];
  logic        busy          [3];
  logic        frame_done    [3];
  logic [15:0] frame_count   [3];

  int test_count = 0;
  int fail_count = 0;
  int rays;
  logic done_seen;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ray_scheduler #(
      .WIDTH   (W),
      .HEIGHT  (H),
      .LATENCY (L),
      .CREDITS (g == 0 ? 16 : (g == 1 ? 2 : 1))
    ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start[g]),
      .cam_in        (cam_in),
      .credit_return (credit_return[g]),
      .cam_out       (cam_out[g]),
      .new_ray       (new_ray[g]),
      .pixel_h       (pixel_h[g]),
      .pixel_v       (pixel_v[g]),
      .tag_valid     (tag_valid[g]),
      .tag_h         (tag_h[g]),
      .tag_v         (tag_v[g]),
      .busy          (busy[g]),
      .frame_done    (frame_done[g]),
      .frame_count   (frame_count[g])
    );
  end

  // Drive inputs for the coming rising edge, then settle just past it.
  task automatic applyStimulus(input logic r, input logic [2:0] st, input logic [2:0] rt);
    rst = r;
    for (int i = 0; i < 3; i++) begin
      start[i]         = st[i];
      credit_return[i] = rt[i];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    test_count++;
    assert (observed === expected)
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    cam_in = CAM1;
    applyStimulus(1'b1, 3'b000, 3'b000);
    applyStimulus(1'b1, 3'b000, 3'b000);
    checkOutput("reset_new_ray",     64'(new_ray[0]),     64'd0);
    checkOutput("reset_pixel_h",     64'(pixel_h[0]),     64'd0);
    checkOutput("reset_cam_out",     64'(cam_out[0]),     64'd0);
    checkOutput("reset_busy",        64'(busy[0]),        64'd0);
    checkOutput("reset_frame_count", 64'(frame_count[0]), 64'd0);
    checkOutput("reset_tag_valid",   64'(tag_valid[0]),   64'd0);
    checkOutput("reset_frame_done",  64'(frame_done[0]),  64'd0);

    // Frame 1 on the 16-credit instance: eight back-to-back rays.
    applyStimulus(1'b0, 3'b001, 3'b000);
    checkOutput("start_busy",    64'(busy[0]),    64'd1);
    checkOutput("start_no_ray",  64'(new_ray[0]), 64'd0);
    checkOutput("start_cam_out", 64'(cam_out[0]), 64'(CAM1));
    cam_in = CAM2;
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b0, 3'b000, {2'b00, tag_valid[0]});
      if (k < 8) begin
        checkOutput("f1_new_ray", 64'(new_ray[0]), 64'd1);
        checkOutput("f1_pixel_h", 64'(pixel_h[0]), 64'(k % W));
        checkOutput("f1_pixel_v", 64'(pixel_v[0]), 64'(k / W));
      end else begin
        checkOutput("f1_idle_ray",  64'(new_ray[0]), 64'd0);
        checkOutput("f1_hold_h",    64'(pixel_h[0]), 64'd3);
        checkOutput("f1_hold_v",    64'(pixel_v[0]), 64'd1);
      end
      if (k >= 3 && k <= 10) begin
        checkOutput("f1_tag_valid", 64'(tag_valid[0]), 64'd1);
        checkOutput("f1_tag_h",     64'(tag_h[0]),     64'((k - 3) % W));
        checkOutput("f1_tag_v",     64'(tag_v[0]),     64'((k - 3) / W));
      end else begin
        checkOutput("f1_tag_idle",  64'(tag_valid[0]), 64'd0);
      end
      checkOutput("f1_frame_done", 64'(frame_done[0]), 64'(k == 11));
    end
    checkOutput("f1_frame_count", 64'(frame_count[0]), 64'd1);
    checkOutput("f1_cam_held",    64'(cam_out[0]),     64'(CAM1));
    applyStimulus(1'b0, 3'b000, 3'b000);
    checkOutput("f1_back_idle", 64'(busy[0]),       64'd0);
    checkOutput("f1_done_once", 64'(frame_done[0]), 64'd0);

    // Frame 2: a second start during RUN must be ignored.
    applyStimulus(1'b0, 3'b001, 3'b000);
    cam_in    = CAM3;
    rays      = 0;
    done_seen = 1'b0;
    for (int k = 0; k < 40 && !done_seen; k++) begin
      applyStimulus(1'b0, (k == 2) ? 3'b001 : 3'b000, {2'b00, tag_valid[0]});
      if (new_ray[0]) rays++;
      if (frame_done[0]) done_seen = 1'b1;
    end
    checkOutput("f2_done_seen",   64'(done_seen),      64'd1);
    checkOutput("f2_ray_count",   64'(rays),           64'd8);
    checkOutput("f2_cam_out",     64'(cam_out[0]),     64'(CAM2));
    checkOutput("f2_frame_count", 64'(frame_count[0]), 64'd2);
    applyStimulus(1'b0, 3'b000, 3'b000);

    // Two credits, one late return: issue blocked on the cycle the return lands.
    applyStimulus(1'b0, 3'b010, 3'b000);
    for (int k = 0; k < 7; k++) begin
      applyStimulus(1'b0, 3'b000, (k == 4) ? 3'b010 : 3'b000);
      checkOutput("c2_new_ray", 64'(new_ray[1]), 64'(k == 0 || k == 1 || k == 5));
      checkOutput("c2_pixel_h", 64'(pixel_h[1]), 64'((k == 0) ? 0 : ((k < 5) ? 1 : 2)));
      checkOutput("c2_pixel_v", 64'(pixel_v[1]), 64'd0);
      checkOutput("c2_tag_valid", 64'(tag_valid[1]), 64'(k == 3 || k == 4));
      if (k == 3 || k == 4) checkOutput("c2_tag_h", 64'(tag_h[1]), 64'(k - 3));
    end
    checkOutput("c2_still_busy", 64'(busy[1]), 64'd1);

    // One credit with a return every cycle: full rate, full frame.
    applyStimulus(1'b0, 3'b100, 3'b100);
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b0, 3'b000, 3'b100);
      checkOutput("c1_new_ray", 64'(new_ray[2]), 64'(k < 8));
      if (k < 8) begin
        checkOutput("c1_pixel_h", 64'(pixel_h[2]), 64'(k % W));
        checkOutput("c1_pixel_v", 64'(pixel_v[2]), 64'(k / W));
      end
      checkOutput("c1_frame_done", 64'(frame_done[2]), 64'(k == 11));
    end
    checkOutput("c1_frame_count", 64'(frame_count[2]), 64'd1);

    // Reset after three issues abandons the frame.
    applyStimulus(1'b0, 3'b001, 3'b000);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 3'b000, 3'b000);
      checkOutput("rst_pre_ray", 64'(new_ray[0]), 64'd1);
      checkOutput("rst_pre_h",   64'(pixel_h[0]), 64'(k));
    end
    applyStimulus(1'b1, 3'b000, 3'b000);
    checkOutput("rst_new_ray",     64'(new_ray[0]),     64'd0);
    checkOutput("rst_pixel_h",     64'(pixel_h[0]),     64'd0);
    checkOutput("rst_cam_out",     64'(cam_out[0]),     64'd0);
    checkOutput("rst_tag_valid",   64'(tag_valid[0]),   64'd0);
    checkOutput("rst_busy",        64'(busy[0]),        64'd0);
    checkOutput("rst_frame_count", 64'(frame_count[0]), 64'd0);
    checkOutput("rst_c2_busy",     64'(busy[1]),        64'd0);
    done_seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 3'b000, 3'b000);
      if (frame_done[0] || tag_valid[0]) done_seen = 1'b1;
    end
    checkOutput("rst_no_done_or_tag", 64'(done_seen), 64'd0);
    applyStimulus(1'b0, 3'b001, 3'b000);
    applyStimulus(1'b0, 3'b000, 3'b000);
    checkOutput("rst_restart_ray", 64'(new_ray[0]), 64'd1);
    checkOutput("rst_restart_h",   64'(pixel_h[0]), 64'd0);
    checkOutput("rst_restart_v",   64'(pixel_v[0]), 64'd0);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
